// File: rtl/scan_loader_pkg.sv
// Shared definitions for the scan-chain loader.
//   state_t             : pass sequencer states
//   DEFAULT_CHAIN_LEN   : scan flops in the memory/IO/key chain (15x8 + 1 + 7 + 16)
//   calc_nbytes/calc_rem: host bytes per pass and valid bits in the final byte
package scan_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        EMIT,
        DONE
    } state_t;

    localparam int DEFAULT_CHAIN_LEN = 144;

    function automatic int calc_nbytes(input int chain_len, input int data_width);
        return (chain_len + data_width - 1) / data_width;
    endfunction

    // Valid bits in the last byte: DATA_WIDTH when the chain divides evenly.
    function automatic int calc_rem(input int chain_len, input int data_width);
        return chain_len - (calc_nbytes(chain_len, data_width) - 1) * data_width;
    endfunction

endpackage

// File: rtl/scan_byte_serdes.sv
// One-byte shift register used as both serializer and deserializer.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : parallel load of load_data (takes priority over shift_en)
//   shift_en   : shift right by one; serial_in enters at the MSB
//   load_data  : byte to load
//   serial_in  : bit captured from the chain
//   data       : current register contents; data[0] is the outgoing bit
module scan_byte_serdes #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shreg_reg;
    logic [DATA_WIDTH-1:0] shreg_next;

    // Written as shift-then-overwrite so a one-bit width still elaborates.
    always_comb begin
        shreg_next                 = shreg_reg >> 1;
        shreg_next[DATA_WIDTH-1]   = serial_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= load_data;
        end else if (shift_en) begin
            shreg_reg <= shreg_next;
        end
    end

    assign data = shreg_reg;

endmodule

// File: rtl/scan_chain_loader.sv
// Scan-chain initiator: shifts CHAIN_LEN bits from a host byte stream into the
// chain while capturing the bits that fall out, returned as a byte stream.
//   clk, rst                 : clock, asynchronous active-high reset
//   start / busy / done      : pass request, pass in progress, end-of-pass pulse
//   in_data/in_valid/in_ready: host byte stream to program (LSB shifted first)
//   out_data/out_valid/out_ready : captured byte stream
//   chain_scan_enable/chain_scan_in : registered drives to the chain
//   chain_scan_out           : chain output, sampled on each shifting edge
// Build option: SCAN_LOADER_READBACK_EN enables the capture path and EMIT state;
// without it the block is write-only (out_* tied 0, out_ready ignored).
module scan_chain_loader
    import scan_loader_pkg::*;
#(
    parameter int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  chain_scan_enable,
    output logic                  chain_scan_in,
    input  logic                  chain_scan_out
);

    localparam int NBYTES = calc_nbytes(CHAIN_LEN, DATA_WIDTH);
    localparam int REM    = calc_rem(CHAIN_LEN, DATA_WIDTH);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t              state_reg, state_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic                scan_en_reg, scan_in_reg, scan_in_next;
    logic                load, shift_en, ser_in, next_lsb, last_byte;
    logic [BIT_W-1:0]    bit_last;
    logic [DATA_WIDTH-1:0] ser_data;

    scan_byte_serdes #(.DATA_WIDTH(DATA_WIDTH)) u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (in_data),
        .serial_in (ser_in),
        .data      (ser_data)
    );

    assign last_byte = (byte_cnt_reg == BYTE_W'(NBYTES - 1));
    assign bit_last  = last_byte ? BIT_W'(REM - 1) : BIT_W'(DATA_WIDTH - 1);

    // Bit that reaches the serdes LSB after one more shift.
    if (DATA_WIDTH > 1) begin : g_next_lsb
        assign next_lsb = ser_data[1];
    end else begin : g_next_lsb_1b
        assign next_lsb = 1'b0;
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        load          = 1'b0;
        shift_en      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = FETCH;
                    byte_cnt_next = '0;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    load         = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                shift_en     = 1'b1;
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == bit_last) begin
`ifdef SCAN_LOADER_READBACK_EN
                    state_next = EMIT;
`else
                    if (last_byte) begin
                        state_next = DONE;
                    end else begin
                        state_next    = FETCH;
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end
`endif
                end
            end
`ifdef SCAN_LOADER_READBACK_EN
            EMIT: begin
                if (out_ready) begin
                    if (last_byte) begin
                        state_next = DONE;
                    end else begin
                        state_next    = FETCH;
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // scan_in is registered together with scan_enable so the chain sees the
    // bit for a SHIFT cycle exactly during that cycle.
    always_comb begin
        scan_in_next = 1'b0;
        if (state_next == SHIFT) begin
            scan_in_next = load ? in_data[0] : next_lsb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            scan_en_reg  <= 1'b0;
            scan_in_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            scan_en_reg  <= (state_next == SHIFT);
            scan_in_reg  <= scan_in_next;
        end
    end

    assign chain_scan_enable = scan_en_reg;
    assign chain_scan_in     = scan_in_reg;
    assign in_ready          = (state_reg == FETCH);
    assign done              = (state_reg == DONE);
    // busy covers the whole pass including the DONE cycle, so start in DONE is dropped.
    assign busy              = (state_reg != IDLE);

`ifdef SCAN_LOADER_READBACK_EN
    assign ser_in    = chain_scan_out;
    assign out_valid = (state_reg == EMIT);
    // A short final byte has its captured bits at the top of the register;
    // realign them to bit 0 and drop the leftover input bits below them.
    assign out_data  = (state_reg != EMIT) ? '0 :
                       last_byte ? (ser_data >> (DATA_WIDTH - REM)) : ser_data;
`else
    logic unused_inputs;
    assign ser_in        = 1'b0;
    assign out_valid     = 1'b0;
    assign out_data      = '0;
    assign unused_inputs = &{1'b0, out_ready, chain_scan_out, ser_data[0]};
`endif

endmodule
